// File: rtl/ahb_arb_pkg.sv
// Shared constants and types for the two-master AHB-Lite arbiter in front of the
// AHB-to-APB bridge slave port.
package ahb_arb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic {StIdle, StData} arb_state_t;

endpackage

// File: rtl/ahb_req_capture.sv
// Address-phase capture for one AHB-Lite master port.
// Latches HADDR/HWRITE of a qualified NONSEQ/SEQ address phase and holds a pending flag until
// the arbiter issues it to the bridge.
// Ports:
//   clk_i, rst_ni         clock, async active-low reset
//   hsel_i, htrans_i,
//   hready_i              address-phase qualifiers from the master bus
//   haddr_i, hwrite_i     address-phase payload
//   clr_i                 arbiter has issued this request; drop the pending flag
//   pend_o, addr_o,
//   write_o               buffered request
module ahb_req_capture
  import ahb_arb_pkg::*;
#(
  parameter int unsigned AddrWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 hsel_i,
  input  logic [1:0]           htrans_i,
  input  logic                 hready_i,
  input  logic [AddrWidth-1:0] haddr_i,
  input  logic                 hwrite_i,
  input  logic                 clr_i,
  output logic                 pend_o,
  output logic [AddrWidth-1:0] addr_o,
  output logic                 write_o
);

  logic                 pend_q, pend_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic                 write_q, write_d;
  logic                 capture;

  // A new request while one is still buffered is dropped so the buffered one is never lost.
  assign capture = hsel_i & hready_i & ~pend_q &
                   ((htrans_i == HTRANS_NONSEQ) | (htrans_i == HTRANS_SEQ));

  always_comb begin
    pend_d  = pend_q;
    addr_d  = addr_q;
    write_d = write_q;
    if (clr_i) begin
      pend_d = 1'b0;
    end else if (capture) begin
      pend_d  = 1'b1;
      addr_d  = haddr_i;
      write_d = hwrite_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q  <= 1'b0;
      addr_q  <= '0;
      write_q <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      write_q <= write_d;
    end
  end

  assign pend_o  = pend_q;
  assign addr_o  = addr_q;
  assign write_o = write_q;

endmodule

// File: rtl/ahb_apb_bridge_arbiter.sv
// Two-master AHB-Lite arbiter sharing one AHB-to-APB bridge slave port.
// Each master's address phase is buffered, the bridge is granted round-robin with one transfer
// outstanding, and the bridge data phase is routed back to the owning master.
// Ports:
//   hclk_i, hresetn_ni           clock, async active-low reset
//   m{0,1}_h*_i                  AHB-Lite master n address/data-phase inputs
//   m{0,1}_hrdata/hreadyout/
//   hresp_o                      responses to master n
//   s_h*_o                       drive to the bridge slave port
//   s_hrdata/hreadyout/hresp_i   bridge responses
module ahb_apb_bridge_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 hclk_i,
  input  logic                 hresetn_ni,
  input  logic                 m0_hsel_i,
  input  logic [AddrWidth-1:0] m0_haddr_i,
  input  logic [1:0]           m0_htrans_i,
  input  logic                 m0_hwrite_i,
  input  logic [DataWidth-1:0] m0_hwdata_i,
  input  logic                 m0_hready_i,
  output logic [DataWidth-1:0] m0_hrdata_o,
  output logic                 m0_hreadyout_o,
  output logic [1:0]           m0_hresp_o,
  input  logic                 m1_hsel_i,
  input  logic [AddrWidth-1:0] m1_haddr_i,
  input  logic [1:0]           m1_htrans_i,
  input  logic                 m1_hwrite_i,
  input  logic [DataWidth-1:0] m1_hwdata_i,
  input  logic                 m1_hready_i,
  output logic [DataWidth-1:0] m1_hrdata_o,
  output logic                 m1_hreadyout_o,
  output logic [1:0]           m1_hresp_o,
  output logic                 s_hsel_o,
  output logic [AddrWidth-1:0] s_haddr_o,
  output logic [1:0]           s_htrans_o,
  output logic                 s_hwrite_o,
  output logic [DataWidth-1:0] s_hwdata_o,
  output logic                 s_hready_o,
  input  logic [DataWidth-1:0] s_hrdata_i,
  input  logic                 s_hreadyout_i,
  input  logic [1:0]           s_hresp_i
);

  arb_state_t           state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 last_q, last_d;
  logic                 pend0, pend1, clr0, clr1, grant;
  logic [AddrWidth-1:0] addr0, addr1;
  logic                 write0, write1;

  ahb_req_capture #(.AddrWidth(AddrWidth)) u_cap0 (
    .clk_i    (hclk_i),
    .rst_ni   (hresetn_ni),
    .hsel_i   (m0_hsel_i),
    .htrans_i (m0_htrans_i),
    .hready_i (m0_hready_i),
    .haddr_i  (m0_haddr_i),
    .hwrite_i (m0_hwrite_i),
    .clr_i    (clr0),
    .pend_o   (pend0),
    .addr_o   (addr0),
    .write_o  (write0)
  );

  ahb_req_capture #(.AddrWidth(AddrWidth)) u_cap1 (
    .clk_i    (hclk_i),
    .rst_ni   (hresetn_ni),
    .hsel_i   (m1_hsel_i),
    .htrans_i (m1_htrans_i),
    .hready_i (m1_hready_i),
    .haddr_i  (m1_haddr_i),
    .hwrite_i (m1_hwrite_i),
    .clr_i    (clr1),
    .pend_o   (pend1),
    .addr_o   (addr1),
    .write_o  (write1)
  );

  // Tie goes to the master that did not win last; otherwise the only requester wins.
  assign grant = (pend0 & pend1) ? ~last_q : pend1;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    clr0       = 1'b0;
    clr1       = 1'b0;
    s_hsel_o   = 1'b0;
    s_htrans_o = HTRANS_IDLE;
    s_haddr_o  = '0;
    s_hwrite_o = 1'b0;
    s_hwdata_o = '0;
    s_hready_o = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (pend0 | pend1) begin
          // SEQ from a master is reissued as NONSEQ: the bridge never sees a burst.
          s_hsel_o   = 1'b1;
          s_htrans_o = HTRANS_NONSEQ;
          s_haddr_o  = grant ? addr1 : addr0;
          s_hwrite_o = grant ? write1 : write0;
          clr0       = ~grant;
          clr1       = grant;
          owner_d    = grant;
          last_d     = grant;
          state_d    = StData;
        end
      end
      StData: begin
        s_hwdata_o = owner_q ? m1_hwdata_i : m0_hwdata_i;
        s_hready_o = s_hreadyout_i;
        if (s_hreadyout_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    m0_hreadyout_o = 1'b1;
    m0_hresp_o     = HRESP_OKAY;
    m0_hrdata_o    = '0;
    m1_hreadyout_o = 1'b1;
    m1_hresp_o     = HRESP_OKAY;
    m1_hrdata_o    = '0;
    if (pend0) begin
      m0_hreadyout_o = 1'b0;
    end else if ((state_q == StData) && !owner_q) begin
      m0_hreadyout_o = s_hreadyout_i;
      m0_hresp_o     = s_hresp_i;
      m0_hrdata_o    = s_hrdata_i;
    end
    if (pend1) begin
      m1_hreadyout_o = 1'b0;
    end else if ((state_q == StData) && owner_q) begin
      m1_hreadyout_o = s_hreadyout_i;
      m1_hresp_o     = s_hresp_i;
      m1_hrdata_o    = s_hrdata_i;
    end
  end

  always_ff @(posedge hclk_i or negedge hresetn_ni) begin
    if (!hresetn_ni) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_ahb_apb_bridge_arbiter.sv
module tb_ahb_apb_bridge_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_hsel, m0_hwrite, m0_hready, m1_hsel, m1_hwrite, m1_hready;
  logic [31:0] m0_haddr, m0_hwdata, m1_haddr, m1_hwdata;
  logic [1:0]  m0_htrans, m1_htrans;
  logic [31:0] m0_hrdata, m1_hrdata;
  logic        m0_hreadyout, m1_hreadyout;
  logic [1:0]  m0_hresp, m1_hresp;
  logic        s_hsel, s_hwrite, s_hready;
  logic [31:0] s_haddr, s_hwdata, s_hrdata;
  logic [1:0]  s_htrans, s_hresp;
  logic        s_hreadyout;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ahb_apb_bridge_arbiter #(.AddrWidth(32), .DataWidth(32)) dut (
    .hclk_i         (clk),
    .hresetn_ni     (rst_n),
    .m0_hsel_i      (m0_hsel),
    .m0_haddr_i     (m0_haddr),
    .m0_htrans_i    (m0_htrans),
    .m0_hwrite_i    (m0_hwrite),
    .m0_hwdata_i    (m0_hwdata),
    .m0_hready_i    (m0_hready),
    .m0_hrdata_o    (m0_hrdata),
    .m0_hreadyout_o (m0_hreadyout),
    .m0_hresp_o     (m0_hresp),
    .m1_hsel_i      (m1_hsel),
    .m1_haddr_i     (m1_haddr),
    .m1_htrans_i    (m1_htrans),
    .m1_hwrite_i    (m1_hwrite),
    .m1_hwdata_i    (m1_hwdata),
    .m1_hready_i    (m1_hready),
    .m1_hrdata_o    (m1_hrdata),
    .m1_hreadyout_o (m1_hreadyout),
    .m1_hresp_o     (m1_hresp),
    .s_hsel_o       (s_hsel),
    .s_haddr_o      (s_haddr),
    .s_htrans_o     (s_htrans),
    .s_hwrite_o     (s_hwrite),
    .s_hwdata_o     (s_hwdata),
    .s_hready_o     (s_hready),
    .s_hrdata_i     (s_hrdata),
    .s_hreadyout_i  (s_hreadyout),
    .s_hresp_i      (s_hresp)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next cycle: inputs change 1 time unit after the edge, checks follow at +2.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic m0_req(input logic [1:0] tr, input logic [31:0] a, input logic w);
    m0_hsel = 1'b1; m0_htrans = tr; m0_haddr = a; m0_hwrite = w; m0_hready = 1'b1;
  endtask

  task automatic m1_req(input logic [1:0] tr, input logic [31:0] a, input logic w);
    m1_hsel = 1'b1; m1_htrans = tr; m1_haddr = a; m1_hwrite = w; m1_hready = 1'b1;
  endtask

  task automatic m0_idle(input logic rdy);
    m0_hsel = 1'b0; m0_htrans = 2'b00; m0_hready = rdy;
  endtask

  task automatic m1_idle(input logic rdy);
    m1_hsel = 1'b0; m1_htrans = 2'b00; m1_hready = rdy;
  endtask

  task automatic bridge(input logic rdy, input logic [1:0] resp, input logic [31:0] rd);
    s_hreadyout = rdy; s_hresp = resp; s_hrdata = rd;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".s_hsel"}, s_hsel, 1'b0);
    chk({tag, ".s_htrans"}, s_htrans, 2'b00);
    chk({tag, ".s_haddr"}, s_haddr, 32'h0);
    chk({tag, ".s_hwrite"}, s_hwrite, 1'b0);
    chk({tag, ".s_hwdata"}, s_hwdata, 32'h0);
    chk({tag, ".s_hready"}, s_hready, 1'b1);
    chk({tag, ".m0_rdy"}, m0_hreadyout, 1'b1);
    chk({tag, ".m0_resp"}, m0_hresp, 2'b00);
    chk({tag, ".m0_rdata"}, m0_hrdata, 32'h0);
    chk({tag, ".m1_rdy"}, m1_hreadyout, 1'b1);
    chk({tag, ".m1_resp"}, m1_hresp, 2'b00);
    chk({tag, ".m1_rdata"}, m1_hrdata, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    m0_idle(1'b1); m0_haddr = '0; m0_hwrite = 1'b0; m0_hwdata = '0;
    m1_idle(1'b1); m1_haddr = '0; m1_hwrite = 1'b0; m1_hwdata = '0;
    bridge(1'b1, 2'b00, 32'h0);
    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Tie straight after reset: M0 first, then M1.
    tick();
    m0_req(2'b10, 32'h0000_0100, 1'b0);
    m1_req(2'b10, 32'h0000_0200, 1'b1);
    tick();
    m0_idle(1'b0); m1_idle(1'b0); m1_hwdata = 32'hCAFE_0001;
    settle();
    chk("tie1.s_hsel", s_hsel, 1'b1);
    chk("tie1.s_htrans", s_htrans, 2'b10);
    chk("tie1.s_haddr", s_haddr, 32'h0000_0100);
    chk("tie1.s_hwrite", s_hwrite, 1'b0);
    chk("tie1.m0_rdy", m0_hreadyout, 1'b0);
    chk("tie1.m1_rdy", m1_hreadyout, 1'b0);
    tick();
    bridge(1'b1, 2'b00, 32'h1111_1111); m0_hready = 1'b1;
    settle();
    chk("tie1.d0.m0_rdata", m0_hrdata, 32'h1111_1111);
    chk("tie1.d0.m0_rdy", m0_hreadyout, 1'b1);
    chk("tie1.d0.m1_rdy", m1_hreadyout, 1'b0);
    chk("tie1.d0.m1_rdata", m1_hrdata, 32'h0);
    chk("tie1.d0.s_hsel", s_hsel, 1'b0);
    tick();
    bridge(1'b1, 2'b00, 32'h0);
    settle();
    chk("tie1.a1.s_hsel", s_hsel, 1'b1);
    chk("tie1.a1.s_haddr", s_haddr, 32'h0000_0200);
    chk("tie1.a1.s_hwrite", s_hwrite, 1'b1);
    chk("tie1.a1.m1_rdy", m1_hreadyout, 1'b0);
    tick();
    m1_hready = 1'b1;
    settle();
    chk("tie1.d1.s_hwdata", s_hwdata, 32'hCAFE_0001);
    chk("tie1.d1.m1_rdy", m1_hreadyout, 1'b1);
    chk("tie1.d1.m0_rdy", m0_hreadyout, 1'b1);
    tick();

    // Single M0 write, bridge inserts 2 wait states.
    m0_req(2'b10, 32'h4000_0010, 1'b1);
    settle();
    chk("wr.pre.m0_rdy", m0_hreadyout, 1'b1);
    tick();
    m0_idle(1'b0); m0_hwdata = 32'hDEAD_BEEF;
    settle();
    chk("wr.a.s_hsel", s_hsel, 1'b1);
    chk("wr.a.s_htrans", s_htrans, 2'b10);
    chk("wr.a.s_haddr", s_haddr, 32'h4000_0010);
    chk("wr.a.s_hwrite", s_hwrite, 1'b1);
    chk("wr.a.m0_rdy", m0_hreadyout, 1'b0);
    tick();
    bridge(1'b0, 2'b00, 32'h0);
    settle();
    chk("wr.w1.s_htrans", s_htrans, 2'b00);
    chk("wr.w1.s_hwdata", s_hwdata, 32'hDEAD_BEEF);
    chk("wr.w1.s_hready", s_hready, 1'b0);
    chk("wr.w1.m0_rdy", m0_hreadyout, 1'b0);
    chk("wr.w1.m1_rdy", m1_hreadyout, 1'b1);
    tick();
    settle();
    chk("wr.w2.m0_rdy", m0_hreadyout, 1'b0);
    tick();
    bridge(1'b1, 2'b00, 32'h0); m0_hready = 1'b1;
    settle();
    chk("wr.done.m0_rdy", m0_hreadyout, 1'b1);
    chk("wr.done.s_hready", s_hready, 1'b1);
    tick();
    settle();
    chk("wr.after.s_hsel", s_hsel, 1'b0);
    chk("wr.after.s_hwdata", s_hwdata, 32'h0);

    // Repeat tie after M0 was last granted: M1 goes first.
    m0_req(2'b10, 32'h0000_0300, 1'b0);
    m1_req(2'b10, 32'h0000_0304, 1'b0);
    tick();
    m0_idle(1'b0); m1_idle(1'b0);
    settle();
    chk("tie2.a.s_haddr", s_haddr, 32'h0000_0304);
    chk("tie2.a.m0_rdy", m0_hreadyout, 1'b0);
    tick();
    bridge(1'b1, 2'b00, 32'h2222_2222); m1_hready = 1'b1;
    settle();
    chk("tie2.d.m1_rdata", m1_hrdata, 32'h2222_2222);
    chk("tie2.d.m0_rdata", m0_hrdata, 32'h0);
    tick();
    bridge(1'b1, 2'b00, 32'h0);
    settle();
    chk("tie2.a2.s_haddr", s_haddr, 32'h0000_0300);
    tick();
    m0_hready = 1'b1;
    tick();

    // M1 read arrives while M0 sits in a 4-wait data phase.
    m0_req(2'b10, 32'h0000_0500, 1'b1);
    tick();
    m0_idle(1'b0); m0_hwdata = 32'h0000_0055;
    tick();
    bridge(1'b0, 2'b00, 32'h0);
    m1_req(2'b10, 32'h0000_0600, 1'b0);
    settle();
    chk("ovl.d1.m0_rdy", m0_hreadyout, 1'b0);
    chk("ovl.d1.m1_rdy", m1_hreadyout, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      m1_idle(1'b0);
      settle();
      chk("ovl.wait.m1_rdy", m1_hreadyout, 1'b0);
      chk("ovl.wait.s_hsel", s_hsel, 1'b0);
    end
    tick();
    bridge(1'b1, 2'b00, 32'h0); m0_hready = 1'b1;
    settle();
    chk("ovl.d5.m0_rdy", m0_hreadyout, 1'b1);
    chk("ovl.d5.m1_rdy", m1_hreadyout, 1'b0);
    tick();
    settle();
    chk("ovl.a.s_haddr", s_haddr, 32'h0000_0600);
    chk("ovl.a.s_hsel", s_hsel, 1'b1);
    chk("ovl.a.m1_rdy", m1_hreadyout, 1'b0);
    tick();
    bridge(1'b1, 2'b00, 32'h6666_6666); m1_hready = 1'b1;
    settle();
    chk("ovl.d.m1_rdy", m1_hreadyout, 1'b1);
    chk("ovl.d.m1_rdata", m1_hrdata, 32'h6666_6666);
    tick();
    bridge(1'b1, 2'b00, 32'h0);

    // Two-cycle ERROR to M0 passes through; M1 stays OKAY.
    m0_req(2'b10, 32'h0000_0700, 1'b0);
    tick();
    m0_idle(1'b0);
    tick();
    bridge(1'b0, 2'b01, 32'h0);
    settle();
    chk("err.c1.m0_rdy", m0_hreadyout, 1'b0);
    chk("err.c1.m0_resp", m0_hresp, 2'b01);
    chk("err.c1.m1_resp", m1_hresp, 2'b00);
    chk("err.c1.m1_rdy", m1_hreadyout, 1'b1);
    tick();
    bridge(1'b1, 2'b01, 32'h0); m0_hready = 1'b1;
    settle();
    chk("err.c2.m0_rdy", m0_hreadyout, 1'b1);
    chk("err.c2.m0_resp", m0_hresp, 2'b01);
    chk("err.c2.m1_resp", m1_hresp, 2'b00);
    tick();
    bridge(1'b1, 2'b00, 32'h0);
    settle();
    chk("err.after.m0_resp", m0_hresp, 2'b00);

    // BUSY is not captured; SEQ is issued as NONSEQ; next NONSEQ captured in completing cycle.
    m0_req(2'b01, 32'h0000_0800, 1'b0);
    tick();
    settle();
    chk("busy.s_htrans", s_htrans, 2'b00);
    chk("busy.s_hsel", s_hsel, 1'b0);
    chk("busy.m0_rdy", m0_hreadyout, 1'b1);
    #0;
    m0_req(2'b11, 32'h0000_0804, 1'b0);
    tick();
    m0_idle(1'b0);
    settle();
    chk("seq.s_htrans", s_htrans, 2'b10);
    chk("seq.s_haddr", s_haddr, 32'h0000_0804);
    tick();
    m0_req(2'b10, 32'h0000_0900, 1'b1);
    settle();
    chk("b2b.d.m0_rdy", m0_hreadyout, 1'b1);
    tick();
    m0_idle(1'b0);
    settle();
    chk("b2b.a.s_hsel", s_hsel, 1'b1);
    chk("b2b.a.s_haddr", s_haddr, 32'h0000_0900);
    chk("b2b.a.s_hwrite", s_hwrite, 1'b1);
    tick();
    m0_hready = 1'b1;
    tick();

    // Reset during DATA with M1 pending: everything clears asynchronously.
    m0_req(2'b10, 32'h0000_0A00, 1'b1);
    tick();
    m0_idle(1'b0); m0_hwdata = 32'h0000_00AA;
    tick();
    bridge(1'b0, 2'b00, 32'h0);
    m1_req(2'b10, 32'h0000_0B00, 1'b0);
    tick();
    m1_idle(1'b0); m0_hready = 1'b1; m1_hready = 1'b1;
    bridge(1'b1, 2'b00, 32'h0);
    settle();
    chk("rst.pre.m1_rdy", m1_hreadyout, 1'b0);
    rst_n = 1'b0;
    #2;
    chk_reset_outputs("rst.mid");
    tick();
    rst_n = 1'b1;
    tick();
    settle();
    chk_reset_outputs("rst.after");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
